matmul_mac_sequencer: RTL and testbench

//   Downstream consumer of the 2-bit element step count. Computes C = A x B for
//   2x2 unsigned matrices with a single shared multiply-accumulate, one product/cycle.

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/mm_idx_counter.sv | 31 +++
 rtl/matmul_mac_sequencer.sv | 169 ++++++++++++++++
 tb/tb_matmul_mac_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the 2x2 matrix multiply sequencer.
//   - state_e     : sequencer FSM encoding (idle, multiply-accumulate, output, done)
//   - IdxC00..C11 : element index constants, idx = {i, j}
//   - acc_w()     : accumulator width for a given operand width
package matmul_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StOut  = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [1:0] IdxC00 = 2'd0;
    localparam logic [1:0] IdxC01 = 2'd1;
    localparam logic [1:0] IdxC10 = 2'd2;
    localparam logic [1:0] IdxC11 = 2'd3;

    // Two 2W-bit products summed need one extra bit.
    function automatic int unsigned acc_w(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mm_idx_counter.sv
// mm_idx_counter: 2-bit element index counter for the matmul sequencer.
// Ports:
//   clk    in  1  clock, rising edge
//   clr_i  in  1  synchronous clear to 0 (takes priority over ce_i)
//   ce_i   in  1  count enable, increments by one with 2-bit wrap
//   idx_o  out 2  current element index
module mm_idx_counter (
    input  logic       clk,
    input  logic       clr_i,
    input  logic       ce_i,
    output logic [1:0] idx_o
);

    logic [1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (ce_i) begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/matmul_mac_sequencer.sv
// matmul_mac_sequencer: computes C = A x B for 2x2 unsigned matrices with one shared
// multiply-accumulate (one product per cycle) and emits C00, C01, C10, C11 in order over a
// valid/ready port.
// Optional feature: define MATMUL_SAT_EN to clamp each result to SAT_MAX (out_sat flags it).
// Ports:
//   clk        in   1      clock, rising edge
//   mr         in   1      master reset, synchronous, active-high
//   start      in   1      begin a multiply (only honoured in idle)
//   a_mat      in   4*W    A, element k=row*2+col at [k*W +: W]
//   b_mat      in   4*W    B, same packing
//   busy       out  1      operation in progress (not asserted in the done cycle)
//   out_valid  out  1      out_data/out_idx hold a C element
//   out_ready  in   1      consumer accepts when out_valid && out_ready
//   out_idx    out  2      element index {i, j}
//   out_data   out  ACC_W  C[i][j]
//   out_sat    out  1      element was clamped
//   done       out  1      one-cycle pulse after the C11 handshake
module matmul_mac_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned SAT_MAX = 255,
    localparam int unsigned ACC_W  = acc_w(W)
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             start,
    input  logic [4*W-1:0]   a_mat,
    input  logic [4*W-1:0]   b_mat,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_idx,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic             done
);

    state_e             state_q, state_d;
    logic [4*W-1:0]     a_q, a_d;
    logic [4*W-1:0]     b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               term_q, term_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;

    logic [1:0]         idx;
    logic               start_accept;
    logic               handshake;
    logic [1:0]         a_k, b_k;
    logic [W-1:0]       a_el, b_el;
    logic [2*W-1:0]     prod;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   load_data;
    logic               load_sat;

    assign start_accept = (state_q == StIdle) && start;
    assign handshake    = (state_q == StOut) && out_ready;

    // Index is cleared on reset or a new run and only advances on a non-final handshake,
    // so it never wraps within a run.
    mm_idx_counter u_idx_counter (
        .clk   (clk),
        .clr_i (mr || start_accept),
        .ce_i  (handshake && (idx != IdxC11)),
        .idx_o (idx)
    );

    // C[i][j] += A[i][term] * B[term][j]
    assign a_k  = {idx[1], term_q};
    assign b_k  = {term_q, idx[0]};
    assign a_el = a_q[32'(a_k) * W +: W];
    assign b_el = b_q[32'(b_k) * W +: W];
    assign prod = (2 * W)'(a_el) * (2 * W)'(b_el);
    assign sum  = acc_q + ACC_W'(prod);

`ifdef MATMUL_SAT_EN
    localparam logic [ACC_W-1:0] SatMaxW = ACC_W'(SAT_MAX);

    always_comb begin
        load_data = sum;
        load_sat  = 1'b0;
        if (sum > SatMaxW) begin
            load_data = SatMaxW;
            load_sat  = 1'b1;
        end
    end
`else
    logic unused_sat_max;
    assign unused_sat_max = (SAT_MAX != 0);
    assign load_data      = sum;
    assign load_sat       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        term_d     = term_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    acc_d   = '0;
                    term_d  = 1'b0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d  = sum;
                term_d = ~term_q;
                if (term_q) begin
                    out_data_d = load_data;
                    out_sat_d  = load_sat;
                    state_d    = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (idx == IdxC11) begin
                        state_d = StDone;
                    end else begin
                        acc_d   = '0;
                        term_d  = 1'b0;
                        state_d = StMac;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mr) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            term_q     <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            term_q     <= term_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign busy      = (state_q == StMac) || (state_q == StOut);
    assign out_valid = (state_q == StOut);
    assign done      = (state_q == StDone);
    assign out_idx   = idx;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Testbench for matmul_mac_sequencer (W=8). Expected C elements are pushed to a scoreboard
// queue at start and popped by a monitor on each output handshake.
module tb_matmul_mac_sequencer;

    localparam int W     = 8;
    localparam int ACC_W = 2 * W + 1;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [1:0]       idx;
        logic             sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             mr = 1'b1;
    logic             start = 1'b0;
    logic [4*W-1:0]   a_mat = '0;
    logic [4*W-1:0]   b_mat = '0;
    logic             busy;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [1:0]       out_idx;
    logic [ACC_W-1:0] out_data;
    logic             out_sat;
    logic             done;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    matmul_mac_sequencer #(
        .W       (W),
        .SAT_MAX (255)
    ) dut (
        .clk       (clk),
        .mr        (mr),
        .start     (start),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!mr && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: idx=%0d data=%0d, no result expected",
                         out_idx, out_data);
            end else begin
                mon_e = sb.pop_front();
                if (out_data !== mon_e.data || out_idx !== mon_e.idx || out_sat !== mon_e.sat) begin
                    n_err++;
                    $display("FAIL result: got idx=%0d data=%0d sat=%0d, want idx=%0d data=%0d sat=%0d",
                             out_idx, out_data, out_sat, mon_e.idx, mon_e.data, mon_e.sat);
                end
            end
        end
    end

    function automatic logic [4*W-1:0] pack(input int e0, input int e1, input int e2, input int e3);
        return {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    task automatic push_expected(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
        for (int k = 0; k < 4; k++) begin
            int i;
            int j;
            int s;
            exp_t e;
            i = k / 2;
            j = k % 2;
            s = int'(a[(i * 2) * W +: W]) * int'(b[j * W +: W])
              + int'(a[(i * 2 + 1) * W +: W]) * int'(b[(2 + j) * W +: W]);
            e.idx = 2'(k);
`ifdef MATMUL_SAT_EN
            if (s > 255) begin
                e.data = ACC_W'(255);
                e.sat  = 1'b1;
            end else begin
                e.data = ACC_W'(s);
                e.sat  = 1'b0;
            end
`else
            e.data = ACC_W'(s);
            e.sat  = 1'b0;
`endif
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle (cycle 0); returns in cycle 1.
    task automatic start_op(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
        a_mat = a;
        b_mat = b;
        start = 1'b1;
        push_expected(a, b);
        step();
        start = 1'b0;
    endtask

    // Steps until done is seen (returns in the done cycle), bounded.
    task automatic wait_done(input int limit);
        bit found;
        found = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL wait_done: done not seen within %0d cycles, required 1", limit);
        end
    endtask

    task automatic test_reset();
        mr = 1'b1;
        step();
        step();
        mr = 1'b0;
        n_vec++;
        if ({busy, out_valid, out_idx, out_data, out_sat, done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%0b valid=%0b idx=%0d data=%0d sat=%0b done=%0b, required all 0",
                     busy, out_valid, out_idx, out_data, out_sat, done);
        end
    endtask

    task automatic test_identity_latency();
        int vcyc[4];
        int nv;
        int dcyc;
        nv   = 0;
        dcyc = -1;
        for (int k = 0; k < 4; k++) vcyc[k] = -1;
        out_ready = 1'b1;
        start_op(pack(1, 0, 0, 1), pack(1, 2, 3, 4));
        for (int c = 1; c <= 20; c++) begin
            if (out_valid && nv < 4) begin
                vcyc[nv] = c;
                nv++;
            end
            if (done) begin
                dcyc = c;
                step();
                break;
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (vcyc[k] !== 3 * k + 3) begin
                n_err++;
                $display("FAIL valid_cycle_%0d: got cycle %0d, required %0d", k, vcyc[k], 3 * k + 3);
            end
        end
        n_vec++;
        if (dcyc !== 13) begin
            n_err++;
            $display("FAIL done_cycle: got cycle %0d, required 13", dcyc);
        end
    endtask

    // Started in cycle 14 of the previous run, so this also covers back-to-back starts.
    task automatic test_busy_window();
        logic exp_busy;
        out_ready = 1'b1;
        start_op(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        for (int c = 1; c <= 14; c++) begin
            exp_busy = (c <= 12);
            n_vec++;
            if (busy !== exp_busy) begin
                n_err++;
                $display("FAIL busy_cycle_%0d: got %0b, required %0b", c, busy, exp_busy);
            end
            if (c == 13) begin
                n_vec++;
                if (done !== 1'b1) begin
                    n_err++;
                    $display("FAIL done_pulse: got %0b at cycle 13, required 1", done);
                end
            end
            step();
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL busy_window_drain: %0d results left, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit found;
        found = 1'b0;
        out_ready = 1'b1;
        start_op(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_idx == 2'd1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        out_ready = 1'b0;
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL stall_reach: C01 not presented, required within 20 cycles");
        end
        for (int s = 0; s < 5; s++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== ACC_W'(22)) begin
                n_err++;
                $display("FAIL stall_hold_%0d: valid=%0b idx=%0d data=%0d, required 1/1/22",
                         s, out_valid, out_idx, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        wait_done(30);
        step();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL stall_drain: %0d results left, required 0", sb.size());
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        start_op(pack(255, 255, 255, 255), pack(255, 255, 255, 255));
        wait_done(30);
        step();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL overflow_drain: %0d results left, required 0", sb.size());
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        start_op(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        for (int c = 1; c < 7; c++) step();
        n_vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || out_idx !== 2'd2) begin
            n_err++;
            $display("FAIL mid_reset_pos: busy=%0b valid=%0b idx=%0d, required 1/0/2",
                     busy, out_valid, out_idx);
        end
        mr = 1'b1;
        step();
        mr = 1'b0;
        sb.delete();
        n_vec++;
        if ({busy, out_valid, out_idx, out_data, out_sat, done} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: busy=%0b valid=%0b idx=%0d data=%0d sat=%0b done=%0b, required all 0",
                     busy, out_valid, out_idx, out_data, out_sat, done);
        end
        step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_idle: busy=%0b, required 0", busy);
        end
        start_op(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        wait_done(30);
        step();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL restart_drain: %0d results left, required 0", sb.size());
        end
    endtask

    task automatic test_ignore_start();
        out_ready = 1'b1;
        start_op(pack(2, 3, 4, 5), pack(6, 7, 8, 9));
        step();
        // Hold start and scramble the operands for the rest of the run, including done.
        start = 1'b1;
        a_mat = pack(9, 9, 9, 9);
        b_mat = pack(7, 7, 7, 7);
        wait_done(30);
        step();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: busy=%0b valid=%0b after done, required 0/0", busy, out_valid);
        end
        step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done_idle: busy=%0b, required 0", busy);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL ignore_drain: %0d results left, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_identity_latency();
        test_busy_window();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_ignore_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached, required completion");
        $fatal(1);
    end

endmodule
